// File: rtl/edge_period_meter.sv
// edge_period_meter: measures the high time and the period of a signal from the
// single-cycle rise/fall pulses of the upstream edge detector. Each complete
// rise -> fall -> rise cycle produces one record. Records are offered on a
// valid/ready port that has a one-entry holding slot.
module edge_period_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rise_i,
    input  logic             fall_i,
    output logic             meas_valid_o,
    input  logic             meas_ready_i,
    output logic [CNT_W-1:0] high_cnt_o,
    output logic [CNT_W-1:0] period_cnt_o,
    output logic             sat_o,
    output logic             drop_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] pc_q, pc_d;
    logic             sat_q, sat_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             sat_out_q, sat_out_d;
    logic             drop_q, drop_d;
    logic             err_q, err_d;

    // Saturating increments: counters stick at the maximum instead of wrapping.
    logic [CNT_W-1:0] hc_inc;
    logic [CNT_W-1:0] pc_inc;
    assign hc_inc = (hc_q == CNT_MAX) ? hc_q : hc_q + CNT_ONE;
    assign pc_inc = (pc_q == CNT_MAX) ? pc_q : pc_q + CNT_ONE;

    logic accept;
    logic complete;
    assign accept = valid_q & meas_ready_i;

    // Next-state logic: measurement FSM, counters and output slot.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would infer a latch.
        state_d   = state_q;
        hc_d      = hc_q;
        pc_d      = pc_q;
        sat_d     = sat_q;
        valid_d   = valid_q;
        high_d    = high_q;
        period_d  = period_q;
        sat_out_d = sat_out_q;
        drop_d    = 1'b0;
        err_d     = 1'b0;
        complete  = 1'b0;

        // A handshake empties the slot unless a new record is loaded below.
        if (accept) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // A lone fall here is ignored; only a rise starts a measurement.
                if (rise_i) begin
                    hc_d    = CNT_ONE;
                    pc_d    = CNT_ONE;
                    sat_d   = 1'b0;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (rise_i) begin
                    // Missed fall: abort this measurement and restart from this rise.
                    err_d = 1'b1;
                    hc_d  = CNT_ONE;
                    pc_d  = CNT_ONE;
                    sat_d = 1'b0;
                end else if (fall_i) begin
                    pc_d    = pc_inc;
                    sat_d   = sat_q | (pc_inc == CNT_MAX);
                    state_d = LOW;
                end else begin
                    hc_d  = hc_inc;
                    pc_d  = pc_inc;
                    sat_d = sat_q | (hc_inc == CNT_MAX) | (pc_inc == CNT_MAX);
                end
            end
            LOW: begin
                if (rise_i) begin
                    complete = 1'b1;
                    hc_d     = CNT_ONE;
                    pc_d     = CNT_ONE;
                    sat_d    = 1'b0;
                    state_d  = HIGH;
                end else begin
                    pc_d  = pc_inc;
                    sat_d = sat_q | (pc_inc == CNT_MAX);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The finished record uses the counter values from before this cycle's update.
        if (complete) begin
            if (!valid_q || accept) begin
                valid_d   = 1'b1;
                high_d    = hc_q;
                period_d  = pc_q;
                sat_out_d = sat_q;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    // State register: every flop is cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hc_q      <= '0;
            pc_q      <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            high_q    <= '0;
            period_q  <= '0;
            sat_out_q <= 1'b0;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            hc_q      <= hc_d;
            pc_q      <= pc_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
            high_q    <= high_d;
            period_q  <= period_d;
            sat_out_q <= sat_out_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
        end
    end

    assign meas_valid_o = valid_q;
    assign high_cnt_o   = high_q;
    assign period_cnt_o = period_q;
    assign sat_o        = sat_out_q;
    assign drop_o       = drop_q;
    assign err_o        = err_q;

endmodule

// File: doc/edge_period_meter.md
# edge_period_meter

Measures the high time and period of a signal from the single-cycle `rise_i` / `fall_i` pulses produced by the edge-detector stage directly upstream. Each complete cycle (rise → fall → next rise) yields one measurement record. Records are presented on a valid/ready output port with a one-entry holding register. It sits between the edge detector and any consumer of timing data (duty-cycle logic, tachometer, CSR capture).

## Interface
- `CNT_W`, default 16: width of the high-time and period counters.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high.
- `rise_i`  in  1: single-cycle rising-edge pulse from the edge detector.
- `fall_i`  in  1: single-cycle falling-edge pulse from the edge detector.
- `meas_valid_o`  out  1: a measurement record is held on the outputs.
- `meas_ready_i`  in  1: consumer accepts the record when asserted together with `meas_valid_o`.
- `high_cnt_o`  out  CNT_W: cycles from the rise to the fall.
- `period_cnt_o`  out  CNT_W: cycles from the rise to the next rise.
- `sat_o`  out  1: record flag; set if either counter saturated during that measurement.
- `drop_o`  out  1: one-cycle pulse; a completed measurement was discarded because the output slot was full.
- `err_o`  out  1: one-cycle pulse; a protocol violation aborted the measurement in progress.

## Operation
- **Counters.** Internal counters `hc` and `pc` are CNT_W bits wide. They saturate at 2^CNT_W−1 and never wrap.
  - On reaching the maximum, a sticky internal `sat` bit is set. It clears when a new measurement starts.
- **State machine.** States are IDLE, HIGH and LOW; reset enters IDLE.
- **IDLE**
  - `rise_i`: set `hc`=1, `pc`=1, clear `sat`, go to HIGH.
  - `fall_i` is ignored.
- **HIGH**
  - Cycle with neither input: `hc`+=1, `pc`+=1.
  - `fall_i`: `pc`+=1, `hc` unchanged, go to LOW.
  - `rise_i` (fall was missed): pulse `err_o`, emit no record, restart with `hc`=1, `pc`=1, clear `sat`, stay in HIGH.
- **LOW**
  - Cycle with neither input: `pc`+=1.
  - `fall_i` is ignored.
  - `rise_i`: complete the measurement with the current `hc`, `pc` and `sat` (values before update). Restart with `hc`=1, `pc`=1, clear `sat`, go to HIGH.
- **Simultaneous pulses.** If `rise_i` and `fall_i` are asserted in the same cycle, `fall_i` is ignored and `rise_i` acts as described above.
- **Resulting values.** For a rise at cycle t0, fall at t1 and next rise at t2: `high_cnt_o` = t1−t0 and `period_cnt_o` = t2−t0.
- **Output slot.**
  - A completed measurement loads the slot if it is empty or is being accepted in the same cycle (`meas_valid_o` && `meas_ready_i`).
  - Otherwise the new measurement is discarded, `drop_o` pulses, and the held record stays unchanged.
  - Record fields stay stable while `meas_valid_o`=1 and `meas_ready_i`=0.
- **Reset values.** `meas_valid_o`=0, `high_cnt_o`=0, `period_cnt_o`=0, `sat_o`=0, `drop_o`=0, `err_o`=0, counters=0, state=IDLE.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- A record appears with `meas_valid_o`=1 on the cycle after the completing `rise_i`.
- A handshake completes on a rising clock edge with `meas_valid_o` && `meas_ready_i`. `meas_valid_o` drops on the next cycle unless a new record is loaded on that same edge.
- `drop_o` and `err_o` assert on the cycle after the triggering `rise_i`, for exactly one cycle.
- Reset mid-measurement or with the slot full takes effect immediately (asynchronous):
  - the partial measurement and the held record are discarded;
  - after reset release, the first `rise_i` only starts a measurement and emits nothing.
- Throughput is one record per period. The minimum legal period is 2 cycles (rise, fall, rise on consecutive cycles gives high=1, period=2).

## Test plan
- **Basic measurement.** Rise at t=10, fall at t=13, rise at t=20, `meas_ready_i`=1.
  - Expect a record at t=21: high=3, period=10, sat=0, valid for one cycle.
  - The next rise at t=30 yields high=0? No: with no fall between t=20 and t=30, the rise at t=30 is in HIGH, so it gives `err_o` at t=31 and no record.
- **Backpressure and drop.** `meas_ready_i`=0, three full cycles with period 8.
  - The first record is held unchanged.
  - `drop_o` pulses once for each of the 2nd and 3rd completions.
  - Raising `meas_ready_i` accepts the first record; valid falls on the next cycle.
- **Saturation.** `CNT_W`=4, high time 20 cycles, period 30 cycles.
  - Expect high=15, period=15, sat=1.
  - The following unsaturated record (high 3, period 6) has sat=0.
- **Protocol handling.**
  - `fall_i` in IDLE produces no effect.
  - Two rises with no fall between them: `err_o` pulses once and no record is emitted.
  - `rise_i` and `fall_i` together in LOW: treated as a rise and the record is emitted.
- **Reset mid-operation.** Assert reset while in LOW with a record held.
  - All outputs go to 0 immediately.
  - After release, the rise/fall/rise sequence with spacing 2/5 gives exactly one record: high=2, period=5.
- **Accept and load in the same cycle.**
  - Valid record held and `meas_ready_i`=1 in the cycle a new measurement completes.
  - Expect the new record loaded with no `drop_o`, and `meas_valid_o` staying 1 with the new values.
